spi_word_responder: RTL and testbench

SPI responder (slave) that terminates the chip-side end of the 32-bit host SPI link (`sclk`, `ss_n`, `mosi`, `miso`) inside the user project. It oversamples the external SPI pins in the system clock domain, assembles MSB-first words from `mosi`, hands each completed word to the core as a one-cycle strobe, and shifts a reply word out on `miso`. By default the reply is the previous received word (echo/passthrough); the core can override the reply with `tx_load`.

---
 rtl/spi_word_responder.sv | 194 +++++++++++++++++++
 tb/tb_spi_word_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_responder.sv
// spi_word_responder
//   SPI mode-0 responder for the 32-bit host link. The SPI pins are
//   oversampled in the clock domain. MSB-first words are assembled from mosi,
//   and each completed word is presented to the core with a one-cycle
//   rx_valid strobe. A reply word is shifted out on miso. The reply is the
//   previously received word (echo) unless the core supplies one via tx_load.
//
// Ports
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   sclk        SPI clock from host (idle low)
//   ss_n        active-low frame select
//   mosi        host data, MSB first
//   miso        reply data, MSB first
//   tx_data     reply word from core
//   tx_load     strobe: capture tx_data as the next reply
//   rx_data     last complete received word
//   rx_valid    one-cycle pulse when rx_data updates
//   busy        synchronized ss_n is low (frame in progress)
//   frame_error one-cycle pulse on a malformed frame
//
// state     | meaning
// ----------+---------------------------------------------------------
// WAIT_IDLE | after reset; ignore the bus until ss_n is seen high
// IDLE      | no frame; reply register tracks pending word / echo
// SHIFT     | frame open, fewer than WORD_W rises seen
// FULL      | word complete; extra rises only flag an error
module spi_word_responder #(
  parameter int WORD_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_error
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    FULL      = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, ss_rise, ss_fall;

  logic [WORD_W-1:0] rx_shift, tx_shift, echo_reg, tx_hold;
  logic [WORD_W-1:0] rx_word;
  logic [CNT_W-1:0]  bit_cnt;
  logic              pend, extra;

  logic shift_en, capture, err_set, cnt_clr, extra_set;

  // Synchronizers reset to 0 (ss_n looks "selected"). WAIT_IDLE then
  // requires ss_n to be genuinely high before a frame can start, which keeps
  // a frame interrupted by reset from being picked up half-way.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign rx_word   = {rx_shift[WORD_W-2:0], mosi_s};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= WAIT_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    capture   = 1'b0;
    err_set   = 1'b0;
    cnt_clr   = 1'b0;
    extra_set = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (ss_s) state_nxt = IDLE;
      end
      IDLE: begin
        if (ss_fall) begin
          state_nxt = SHIFT;
          cnt_clr   = 1'b1;
        end
      end
      SHIFT: begin
        // A frame closed with no edges at all is not an error.
        if (ss_rise) begin
          state_nxt = IDLE;
          err_set   = (bit_cnt != '0);
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == CNT_W'(WORD_W - 1)) begin
            capture   = 1'b1;
            state_nxt = FULL;
          end
        end
      end
      FULL: begin
        if (ss_rise) begin
          state_nxt = IDLE;
          err_set   = extra;
        end else if (sclk_rise) begin
          extra_set = 1'b1;
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_shift    <= '0;
      tx_shift    <= '0;
      echo_reg    <= '0;
      tx_hold     <= '0;
      rx_data     <= '0;
      bit_cnt     <= '0;
      pend        <= 1'b0;
      extra       <= 1'b0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_valid    <= capture;
      frame_error <= err_set;

      if (cnt_clr) begin
        bit_cnt <= '0;
        extra   <= 1'b0;
      end
      if (extra_set) extra <= 1'b1;

      if (shift_en) begin
        rx_shift <= rx_word;
        bit_cnt  <= bit_cnt + CNT_W'(1);
        tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
      end

      if (capture) begin
        rx_data  <= rx_word;
        echo_reg <= rx_word;
      end

      // Reply register follows its source continuously while idle, so the
      // MSB is already on miso when ss_n falls. A pending core word beats
      // the echo until the next frame starts.
      if (state == IDLE) tx_shift <= pend ? tx_hold : echo_reg;

      if (tx_load) begin
        tx_hold <= tx_data;
        pend    <= 1'b1;
      end else if (state == IDLE && ss_fall) begin
        pend    <= 1'b0;
      end
    end
  end

  assign miso = tx_shift[WORD_W-1];
  // ss_n is not trusted until WAIT_IDLE has seen it high.
  assign busy = ~ss_s & (state != WAIT_IDLE);

endmodule

// File: tb/tb_spi_word_responder.sv
module tb_spi_word_responder;

  logic        clock;
  logic        reset_n;
  logic        sclk;
  logic        ss_n;
  logic        mosi;
  logic        miso;
  logic [31:0] tx_data;
  logic        tx_load;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        frame_error;

  spi_word_responder #(.WORD_W(32), .SYNC_STAGES(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sclk        (sclk),
    .ss_n        (ss_n),
    .mosi        (mosi),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .frame_error (frame_error)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;

  always @(negedge clock) begin
    if (rx_valid === 1'b1)    valid_cnt++;
    if (frame_error === 1'b1) err_cnt++;
  end

  typedef struct {
    logic [31:0] word;
    int          nbits;
    int          load_at;   // -2 none, -1 while idle, k during bit k
    logic [31:0] load_data;
    logic [31:0] exp_read;
    int          exp_valid;
    logic [31:0] exp_rx;
    int          exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load_pulse(input logic [31:0] d);
    tx_data = d;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
  endtask

  task automatic clk_bit(input logic b, output logic m);
    mosi = b;
    wait_clk(4);
    m = miso;
    sclk = 1'b1;
    wait_clk(4);
    sclk = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] w, input int n, input int load_at,
                           input logic [31:0] ld, output logic [31:0] rd);
    logic m;
    logic b;
    rd = '0;
    ss_n = 1'b0;
    wait_clk(4);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i == load_at) load_pulse(ld);
      b = (i < 32) ? w[31-i] : 1'b1;
      clk_bit(b, m);
      rd = {rd[30:0], m};
    end
    wait_clk(4);
    ss_n = 1'b1;
    mosi = 1'b0;
    wait_clk(8);
  endtask

  initial begin
    logic [31:0] rd;
    logic        m;
    int          v0, e0;

    vecs[0]  = '{32'hBEEFFACE, 32, -2, 32'h0,        32'h00000000, 1, 32'hBEEFFACE, 0};
    vecs[1]  = '{32'h00000000, 32, -2, 32'h0,        32'hBEEFFACE, 1, 32'h00000000, 0};
    vecs[2]  = '{32'hA5A5A5A5, 32, -1, 32'h12345678, 32'h12345678, 1, 32'hA5A5A5A5, 0};
    vecs[3]  = '{32'h3C3C3C3C, 32, -2, 32'h0,        32'hA5A5A5A5, 1, 32'h3C3C3C3C, 0};
    vecs[4]  = '{32'h9999FFFF, 16, -2, 32'h0,        32'h00003C3C, 0, 32'h3C3C3C3C, 1};
    vecs[5]  = '{32'hCAFEF00D, 32, -2, 32'h0,        32'h3C3C3C3C, 1, 32'hCAFEF00D, 0};
    vecs[6]  = '{32'hDEADBEEF, 33, -2, 32'h0,        32'h95FDE01A, 1, 32'hDEADBEEF, 1};
    vecs[7]  = '{32'h80000001, 32, -2, 32'h0,        32'hDEADBEEF, 1, 32'h80000001, 0};
    vecs[8]  = '{32'h00000000,  0, -2, 32'h0,        32'h00000000, 0, 32'h80000001, 0};
    vecs[9]  = '{32'h11111111, 32, 10, 32'h0F0F0F0F, 32'h80000001, 1, 32'h11111111, 0};
    vecs[10] = '{32'h22222222, 32, -2, 32'h0,        32'h0F0F0F0F, 1, 32'h22222222, 0};
    vecs[11] = '{32'h00000000, 32, -2, 32'h0,        32'h22222222, 1, 32'h00000000, 0};

    reset_n = 1'b0;
    sclk    = 1'b0;
    ss_n    = 1'b1;
    mosi    = 1'b0;
    tx_data = '0;
    tx_load = 1'b0;
    wait_clk(3);
    check("rst_miso",        {31'd0, miso},        32'd0);
    check("rst_rx_data",     rx_data,              32'd0);
    check("rst_rx_valid",    {31'd0, rx_valid},    32'd0);
    check("rst_busy",        {31'd0, busy},        32'd0);
    check("rst_frame_error", {31'd0, frame_error}, 32'd0);
    reset_n = 1'b1;
    wait_clk(8);
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 12; k++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      if (vecs[k].load_at == -1) begin
        load_pulse(vecs[k].load_data);
        wait_clk(3);
      end
      run_frame(vecs[k].word, vecs[k].nbits, vecs[k].load_at, vecs[k].load_data, rd);
      check($sformatf("v%0d_host_read", k), rd, vecs[k].exp_read);
      check($sformatf("v%0d_rx_valid_cnt", k), 32'(valid_cnt - v0), 32'(vecs[k].exp_valid));
      check($sformatf("v%0d_rx_data", k), rx_data, vecs[k].exp_rx);
      check($sformatf("v%0d_frame_error_cnt", k), 32'(err_cnt - e0), 32'(vecs[k].exp_err));
    end

    // Back-to-back tx_load: the later word must be the reply.
    load_pulse(32'hAAAA0001);
    load_pulse(32'hAAAA0002);
    wait_clk(3);
    v0 = valid_cnt;
    run_frame(32'h13579BDF, 32, -2, 32'h0, rd);
    check("dbl_load_read", rd, 32'hAAAA0002);
    check("dbl_load_rx", rx_data, 32'h13579BDF);
    check("dbl_load_valid_cnt", 32'(valid_cnt - v0), 32'd1);

    // Reset after bit 12, host finishes the frame anyway.
    v0 = valid_cnt;
    e0 = err_cnt;
    ss_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 12; i++) clk_bit(1'b1, m);
    reset_n = 1'b0;
    #1;
    check("mid_rst_miso",        {31'd0, miso},        32'd0);
    check("mid_rst_rx_data",     rx_data,              32'd0);
    check("mid_rst_rx_valid",    {31'd0, rx_valid},    32'd0);
    check("mid_rst_busy",        {31'd0, busy},        32'd0);
    check("mid_rst_frame_error", {31'd0, frame_error}, 32'd0);
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(1);
    for (int i = 12; i < 32; i++) clk_bit(1'b1, m);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    wait_clk(4);
    ss_n = 1'b1;
    mosi = 1'b0;
    wait_clk(8);
    check("post_rst_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check("post_rst_err_cnt",   32'(err_cnt - e0),   32'd0);
    check("post_rst_rx_data",   rx_data,             32'd0);

    v0 = valid_cnt;
    e0 = err_cnt;
    run_frame(32'h55AA55AA, 32, -2, 32'h0, rd);
    check("after_rst_read", rd, 32'h00000000);
    check("after_rst_rx", rx_data, 32'h55AA55AA);
    check("after_rst_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("after_rst_err_cnt", 32'(err_cnt - e0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
